// File: rtl/ram_io_responder.sv
// ram_io_responder: target end of the CPU byte bus.
// Serves a 128KB RAM (mem_a[17]==0), an unmapped hole (mem_a[17:16]==2'b10) and an
// I/O window (mem_a[17:16]==2'b11): console RX/TX at offset 0, cycle counter / program
// stop at offsets 4..7. Console output is buffered in a TX FIFO with a one-byte overflow
// hold register; the CPU is paused through rdy_out while that hold register is occupied.
// Optional feature macro: IO_RX_BLOCKING_EN (blocking console reads when defined).
module ram_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 16,
    parameter int TX_PTR_W   = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt_o
);

    localparam logic [TX_PTR_W:0] FULL_COUNT = (TX_PTR_W + 1)'(TX_DEPTH);

    // Storage
    logic [7:0]          ram [0:(2**RAM_ADDR_W)-1];
    logic [7:0]          ram_q;
    logic [7:0]          tx_mem [0:TX_DEPTH-1];

    // Control state
    logic                din_sel_ram;
    logic [7:0]          io_q;
    logic                hold_valid;
    logic [7:0]          hold_data;
    logic [31:0]         counter;
    logic [31:0]         snapshot;
    logic [TX_PTR_W-1:0] wr_ptr;
    logic [TX_PTR_W-1:0] rd_ptr;
    logic [TX_PTR_W:0]   count;

    // Decode
    logic                sample;
    logic                is_ram;
    logic                is_io;
    logic [2:0]          io_off;
    logic                rd_rx;
    logic                tx_cmd;
    logic [7:0]          tx_byte_in;
    logic                fifo_full;
    logic                pop;
    logic                push_new;
    logic                to_hold;
    logic                drain;
    logic                push;
    logic [7:0]          push_data;
    logic [7:0]          io_rd_byte;
    logic                unused_addr_bits;

    // Upper address bits are not decoded.
    assign unused_addr_bits = &{1'b0, mem_a[31:18]};

    // The bus is only taken in cycles where the CPU is not paused.
    assign sample     = rdy_out;
    assign is_ram     = ~mem_a[17];
    assign is_io      = (mem_a[17:16] == 2'b11);
    assign io_off     = mem_a[2:0];
    assign rd_rx      = sample & ~mem_wr & is_io & (io_off == 3'd0);

    // Console byte writes (non-zero) and the program-stop write both feed the TX FIFO.
    assign tx_cmd     = sample & mem_wr & is_io &
                        (((io_off == 3'd0) && (mem_dout != 8'h00)) || (io_off == 3'd4));
    assign tx_byte_in = (io_off == 3'd4) ? 8'h00 : mem_dout;

    // Fullness is judged before any same-cycle pop; a held byte drains only once there is room.
    assign fifo_full  = (count == FULL_COUNT);
    assign tx_valid   = (count != '0);
    assign pop        = tx_valid & tx_ready;
    assign push_new   = tx_cmd & ~fifo_full;
    assign to_hold    = tx_cmd & fifo_full;
    assign drain      = hold_valid & ~fifo_full;
    assign push       = push_new | drain;
    assign push_data  = drain ? hold_data : tx_byte_in;
    assign tx_data    = tx_valid ? tx_mem[rd_ptr] : 8'h00;

    assign mem_din    = din_sel_ram ? ram_q : io_q;

`ifdef IO_RX_BLOCKING_EN
    logic rx_wait;
    // A byte is consumed either by a direct read or at the end of a blocked read.
    assign rx_ready = rst_n_in & rx_valid & (rd_rx | rx_wait);
`else
    // A byte is consumed only by a read that finds one waiting.
    assign rx_ready = rst_n_in & rx_valid & rd_rx;
`endif

    // I/O read mux: console byte, live counter byte 0, or coherent snapshot bytes 1..3.
    always_comb begin
        io_rd_byte = 8'h00;
        if (is_io) begin
            case (io_off)
                3'd0:    io_rd_byte = rx_valid ? rx_data : 8'h00;
                3'd4:    io_rd_byte = counter[7:0];
                3'd5:    io_rd_byte = snapshot[15:8];
                3'd6:    io_rd_byte = snapshot[23:16];
                3'd7:    io_rd_byte = snapshot[31:24];
                default: io_rd_byte = 8'h00;
            endcase
        end
    end

    // RAM port: write at the sampling edge, registered read; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (sample && is_ram) begin
            if (mem_wr) begin
                ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
            end else begin
                ram_q <= ram[mem_a[RAM_ADDR_W-1:0]];
            end
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk_in) begin
        if (push) begin
            tx_mem[wr_ptr] <= push_data;
        end
    end

    // TX FIFO pointers and occupancy; pointers wrap naturally at TX_DEPTH.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bus response, counter, halt flag, overflow hold and CPU pause control.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            din_sel_ram <= 1'b0;
            io_q        <= 8'h00;
            rdy_out     <= 1'b1;
            hold_valid  <= 1'b0;
            hold_data   <= 8'h00;
            counter     <= 32'd0;
            snapshot    <= 32'd0;
            halt_o      <= 1'b0;
`ifdef IO_RX_BLOCKING_EN
            rx_wait     <= 1'b0;
`endif
        end else begin
            counter <= counter + 32'd1;
            if (sample) begin
                if (mem_wr) begin
                    din_sel_ram <= 1'b0;
                    io_q        <= 8'h00;
                    if (is_io && (io_off == 3'd4)) halt_o <= 1'b1;
                end else if (is_ram) begin
                    din_sel_ram <= 1'b1;
                end else begin
                    din_sel_ram <= 1'b0;
                    io_q        <= io_rd_byte;
                    if (is_io && (io_off == 3'd4)) snapshot <= counter;
                end
            end
            if (to_hold) begin
                hold_valid <= 1'b1;
                hold_data  <= tx_byte_in;
                rdy_out    <= 1'b0;
            end else if (drain) begin
                hold_valid <= 1'b0;
                rdy_out    <= 1'b1;
            end
`ifdef IO_RX_BLOCKING_EN
            if (rd_rx && !rx_valid) begin
                rx_wait <= 1'b1;
                rdy_out <= 1'b0;
            end else if (rx_wait && rx_valid) begin
                rx_wait <= 1'b0;
                io_q    <= rx_data;
                rdy_out <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Testbench for ram_io_responder: table-driven bus vectors plus hand-written
// sequences for the counter snapshot, TX overflow stall, halt, console RX and reset.
module tb_ram_io_responder;

    logic        clk = 1'b0;
    logic        rst_n_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt_o;

    int vec_cnt     = 0;
    int miscompares = 0;

    ram_io_responder dut (
        .clk_in   (clk),
        .rst_n_in (rst_n_in),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .rdy_out  (rdy_out),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .halt_o   (halt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic [7:0]  exp_din;
        logic        exp_rdy;
        logic        exp_txv;
    } vec_t;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        mem_wr   = wr;
        mem_a    = a;
        mem_dout = d;
    endtask

    task automatic check_reset_state(input string tag);
        check8({tag, "_din"},  mem_din,  8'h00);
        check1({tag, "_rdy"},  rdy_out,  1'b1);
        check1({tag, "_rxr"},  rx_ready, 1'b0);
        check1({tag, "_txv"},  tx_valid, 1'b0);
        check8({tag, "_txd"},  tx_data,  8'h00);
        check1({tag, "_halt"}, halt_o,   1'b0);
    endtask

    vec_t vecs[16];
    logic [7:0] got[$];
    bit released;

    initial begin
        rst_n_in = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        drive(1'b0, 32'h0, 8'h00);

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // ---------------- counter snapshot ----------------
        // Released at this negedge; the k-th following posedge sees counter == k-1.
        rst_n_in = 1'b1;
        repeat (511) @(negedge clk);
        drive(1'b0, 32'h0003_0004, 8'h00);          // sampled with counter 0x1FF
        @(negedge clk); check8("cnt_b0", mem_din, 8'hFF);
        drive(1'b0, 32'h0003_0005, 8'h00);
        @(negedge clk); check8("cnt_b1", mem_din, 8'h01);
        drive(1'b0, 32'h0003_0006, 8'h00);
        @(negedge clk); check8("cnt_b2", mem_din, 8'h00);
        drive(1'b0, 32'h0003_0007, 8'h00);
        @(negedge clk); check8("cnt_b3", mem_din, 8'h00);
        drive(1'b0, 32'h0003_0004, 8'h00);          // counter 0x203, relatches snapshot
        @(negedge clk); check8("cnt2_b0", mem_din, 8'h03);
        drive(1'b0, 32'h0003_0005, 8'h00);
        @(negedge clk); check8("cnt2_b1", mem_din, 8'h02);

        // ---------------- table-driven bus vectors ----------------
        //          wr    addr           wdata  rxv   rxd    exp_din exp_rdy exp_txv
        vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h0001_FFFF, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_4000, 8'h33, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'h0002_4000, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'h0002_4000, 8'h55, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_4000, 8'h00, 1'b0, 8'h00, 8'h33, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 32'h0001_0010, 8'h77, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'hFFFC_0010, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h0003_0001, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h0001_0010, 8'h00, 1'b0, 8'h00, 8'h77, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 32'h0003_0001, 8'h12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            @(negedge clk);
            $display("vec %0d: wr=%b a=0x%08h d=0x%02h -> din=0x%02h rdy=%b txv=%b",
                     i, vecs[i].wr, vecs[i].addr, vecs[i].wdata, mem_din, rdy_out, tx_valid);
            check8($sformatf("vec%0d_din", i), mem_din,  vecs[i].exp_din);
            check1($sformatf("vec%0d_rdy", i), rdy_out,  vecs[i].exp_rdy);
            check1($sformatf("vec%0d_txv", i), tx_valid, vecs[i].exp_txv);
        end
        rx_valid = 1'b0;
        drive(1'b0, 32'h0, 8'h00);

        // ---------------- TX FIFO overflow stall ----------------
        for (int b = 1; b <= 17; b++) begin
            drive(1'b1, 32'h0003_0000, 8'(b));
            @(negedge clk);
            if (b == 16) check1("tx_rdy_at16", rdy_out, 1'b1);
        end
        check1("tx_rdy_stall", rdy_out, 1'b0);
        check1("tx_valid_full", tx_valid, 1'b1);
        check8("tx_head", tx_data, 8'h01);
        tx_ready = 1'b1;
        released = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (rdy_out && !released) begin
                released = 1'b1;
                drive(1'b0, 32'h0, 8'h00);
            end
            if (tx_valid) got.push_back(tx_data);
            if (got.size() >= 17 && released) break;
            @(negedge clk);
        end
        check1("tx_rdy_released", released, 1'b1);
        vec_cnt++;
        if (got.size() != 17) begin
            miscompares++;
            $display("FAIL tx_pop_count: got %0d expected 17", got.size());
        end
        for (int i = 0; i < 17 && i < got.size(); i++)
            check8($sformatf("tx_pop%0d", i), got[i], 8'(i + 1));
        @(negedge clk);
        check1("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Zero byte to the console is dropped.
        drive(1'b1, 32'h0003_0000, 8'h00);
        @(negedge clk); check1("tx_zero_dropped", tx_valid, 1'b0);
        drive(1'b0, 32'h0, 8'h00);

        // ---------------- program stop ----------------
        drive(1'b1, 32'h0003_0004, 8'hEE);
        @(negedge clk);
        check1("halt_set", halt_o, 1'b1);
        check1("halt_txv", tx_valid, 1'b1);
        check8("halt_txd", tx_data, 8'h00);
        drive(1'b0, 32'h0, 8'h00);
        tx_ready = 1'b1;
        @(negedge clk);
        check1("halt_tx_popped", tx_valid, 1'b0);
        tx_ready = 1'b0;
        repeat (5) @(negedge clk);
        check1("halt_sticky", halt_o, 1'b1);

        // ---------------- console RX ----------------
`ifdef IO_RX_BLOCKING_EN
        drive(1'b0, 32'h0003_0000, 8'h00);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check1("rxb_rdy_low", rdy_out, 1'b0);
            check1("rxb_no_ready", rx_ready, 1'b0);
            @(negedge clk);
        end
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        #1 check1("rxb_ready_pulse", rx_ready, 1'b1);
        @(negedge clk);
        check1("rxb_rdy_back", rdy_out, 1'b1);
        check8("rxb_din", mem_din, 8'h3C);
        rx_valid = 1'b0;
        drive(1'b0, 32'h0, 8'h00);
        #1 check1("rxb_ready_single", rx_ready, 1'b0);
`else
        drive(1'b0, 32'h0003_0000, 8'h00);
        #1 check1("rx_empty_no_ready", rx_ready, 1'b0);
        @(negedge clk);
        check8("rx_empty_din", mem_din, 8'h00);
        check1("rx_empty_rdy", rdy_out, 1'b1);
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        #1 check1("rx_ready_pulse", rx_ready, 1'b1);
        @(negedge clk);
        check8("rx_din", mem_din, 8'h3C);
        rx_valid = 1'b0;
        drive(1'b0, 32'h0, 8'h00);
        #1 check1("rx_ready_single", rx_ready, 1'b0);
`endif
        @(negedge clk);

        // ---------------- reset during an overflow stall ----------------
        for (int b = 1; b <= 17; b++) begin
            drive(1'b1, 32'h0003_0000, 8'(8'h40 + b));
            @(negedge clk);
        end
        check1("stall2_rdy", rdy_out, 1'b0);
        rst_n_in = 1'b0;
        drive(1'b0, 32'h0, 8'h00);
        #1 check_reset_state("midreset");
        @(negedge clk);
        rst_n_in = 1'b1;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check1("midreset_held_dropped", tx_valid, 1'b0);
        check1("midreset_rdy", rdy_out, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
